// File: rtl/taxi_trip_ctrl.sv
// Taxi trip controller: sequences a fare counter through clear/drive/wait/done and accumulates BCD distance and waiting time.
// Latency: every output is registered; dis/t_min move one cycle after a qualifying pulse. No backpressure: pulses are sampled every cycle.
module taxi_trip_ctrl #(
    parameter int PULSES_PER_KM = 10,
    parameter int TICKS_PER_MIN = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        end_trip,
    input  logic        pause,
    input  logic        wheel_pulse,
    input  logic        sec_tick,
    output logic [11:0] dis,
    output logic [7:0]  t_min,
    output logic        meter_reset,
    output logic        run,
    output logic        finish,
    output logic [2:0]  trip_state
);

    localparam int PW = (PULSES_PER_KM > 1) ? $clog2(PULSES_PER_KM) : 1;
    localparam int SW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DRIVE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pulse_cnt;
    logic [SW-1:0] sec_cnt;

    function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (r[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = r[7:4] + 4'd1;
        end else begin
            r[3:0] = r[3:0] + 4'd1;
        end
        return r;
    endfunction

    // end_trip outranks pause while a trip is in progress
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: state_nxt = pause ? WAIT : DRIVE;
            DRIVE: if (end_trip) state_nxt = DONE;
                   else if (pause) state_nxt = WAIT;
            WAIT:  if (end_trip) state_nxt = DONE;
                   else if (!pause) state_nxt = DRIVE;
            DONE:  if (start) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dis         <= 12'h000;
            t_min       <= 8'h00;
            pulse_cnt   <= '0;
            sec_cnt     <= '0;
            meter_reset <= 1'b1;
            run         <= 1'b0;
            finish      <= 1'b0;
        end else begin
            state       <= state_nxt;
            meter_reset <= (state_nxt == IDLE) || (state_nxt == CLEAR);
            run         <= (state_nxt == DRIVE);
            finish      <= (state_nxt == DONE);

            // Counting is judged on the pre-edge state, so a pulse on the DRIVE->WAIT edge still counts
            if (state_nxt == CLEAR) begin
                dis       <= 12'h000;
                t_min     <= 8'h00;
                pulse_cnt <= '0;
                sec_cnt   <= '0;
            end else if (state == DRIVE && wheel_pulse && dis != 12'h999) begin
                if (pulse_cnt == PW'(PULSES_PER_KM - 1)) begin
                    pulse_cnt <= '0;
                    dis       <= bcd3_inc(dis);
                end else begin
                    pulse_cnt <= pulse_cnt + 1'b1;
                end
            end else if (state == WAIT && sec_tick && t_min != 8'h99) begin
                if (sec_cnt == SW'(TICKS_PER_MIN - 1)) begin
                    sec_cnt <= '0;
                    t_min   <= bcd2_inc(t_min);
                end else begin
                    sec_cnt <= sec_cnt + 1'b1;
                end
            end
        end
    end

    assign trip_state = state;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed bench for taxi_trip_ctrl with hand-computed expectations (10 pulses/km, 60 ticks/min).
module tb_taxi_trip_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, end_trip, pause, wheel_pulse, sec_tick;
    logic [11:0] dis;
    logic [7:0]  t_min;
    logic        meter_reset, run, finish;
    logic [2:0]  trip_state;

    int n_checks = 0;
    int n_pass   = 0;

    taxi_trip_ctrl #(.PULSES_PER_KM(10), .TICKS_PER_MIN(60)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .end_trip    (end_trip),
        .pause       (pause),
        .wheel_pulse (wheel_pulse),
        .sec_tick    (sec_tick),
        .dis         (dis),
        .t_min       (t_min),
        .meter_reset (meter_reset),
        .run         (run),
        .finish      (finish),
        .trip_state  (trip_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        wheel_pulse = 1'b1;
        repeat (n) step();
        wheel_pulse = 1'b0;
    endtask

    task automatic ticks(input int n);
        sec_tick = 1'b1;
        repeat (n) step();
        sec_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; end_trip = 1'b0; pause = 1'b0;
        wheel_pulse = 1'b0; sec_tick = 1'b0;
        repeat (2) step();
        check_val("rst_state", trip_state, 0);
        check_val("rst_mreset", meter_reset, 1);
        check_val("rst_run", run, 0);
        check_val("rst_finish", finish, 0);
        check_val("rst_dis", dis, 12'h000);
        check_val("rst_tmin", t_min, 8'h00);
        reset = 1'b1;
        step();

        // IDLE ignores everything except start
        end_trip = 1'b1; pause = 1'b1; wheel_pulse = 1'b1; sec_tick = 1'b1;
        repeat (3) step();
        end_trip = 1'b0; pause = 1'b0; wheel_pulse = 1'b0; sec_tick = 1'b0;
        check_val("idle_state", trip_state, 0);
        check_val("idle_dis", dis, 12'h000);
        check_val("idle_tmin", t_min, 8'h00);

        start = 1'b1;
        step();
        start = 1'b0;
        check_val("clear_state", trip_state, 1);
        check_val("clear_mreset", meter_reset, 1);
        check_val("clear_run", run, 0);
        step();
        check_val("drive_state", trip_state, 2);
        check_val("drive_run", run, 1);
        check_val("drive_mreset", meter_reset, 0);

        pulses(25);
        check_val("dis_25", dis, 12'h002);
        pulses(5);
        check_val("dis_30", dis, 12'h003);

        pause = 1'b1;
        step();
        check_val("wait_state", trip_state, 3);
        check_val("wait_run", run, 0);
        pulses(15);
        check_val("wait_no_dist", dis, 12'h003);
        ticks(150);
        check_val("tmin_150", t_min, 8'h02);
        pause = 1'b0;
        step();
        check_val("back_drive", trip_state, 2);
        ticks(30);
        check_val("drive_no_tick", t_min, 8'h02);
        pause = 1'b1;
        step();
        ticks(30);
        check_val("tmin_partial", t_min, 8'h03);

        pause = 1'b0;
        step();
        end_trip = 1'b1; pause = 1'b1;
        step();
        end_trip = 1'b0;
        check_val("done_state", trip_state, 4);
        check_val("done_finish", finish, 1);
        check_val("done_run", run, 0);
        check_val("done_mreset", meter_reset, 0);
        end_trip = 1'b1;
        pulses(20);
        ticks(200);
        end_trip = 1'b0;
        check_val("done_hold_dis", dis, 12'h003);
        check_val("done_hold_tmin", t_min, 8'h03);
        check_val("done_stays", trip_state, 4);

        pause = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("restart_clear", trip_state, 1);
        check_val("restart_dis", dis, 12'h000);
        check_val("restart_tmin", t_min, 8'h00);
        step();
        pulses(9980);
        check_val("dis_998", dis, 12'h998);
        pulses(30);
        check_val("dis_sat", dis, 12'h999);
        end_trip = 1'b1;
        step();
        end_trip = 1'b0;
        check_val("sat_done", finish, 1);
        pause = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("sat_clear_dis", dis, 12'h000);
        check_val("sat_clear_state", trip_state, 1);
        step();
        check_val("clear_to_wait", trip_state, 3);
        ticks(70);
        check_val("tmin_70", t_min, 8'h01);

        // Reset lands mid-cycle, well away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        check_val("async_state", trip_state, 0);
        check_val("async_mreset", meter_reset, 1);
        check_val("async_tmin", t_min, 8'h00);
        check_val("async_run", run, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/taxi_trip_ctrl.md
TAXI_TRIP_CTRL -- requirements
Module: taxi_trip_ctrl

Interface
REQ-001 SHALL have parameter PULSES_PER_KM, default 10, wheel pulses per km of distance.
REQ-002 SHALL have parameter TICKS_PER_MIN, default 60, sec_tick pulses per waiting minute.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a trip.
REQ-006 SHALL have port end_trip  input  1  one-cycle pulse that ends a trip.
REQ-007 SHALL have port pause  input  1  level; 1 = vehicle halted (waiting), 0 = moving.
REQ-008 SHALL have port wheel_pulse  input  1  one-cycle pulse per wheel sensor event.
REQ-009 SHALL have port sec_tick  input  1  one-cycle pulse per second.
REQ-010 SHALL have port dis  output  12  distance in km, 3-digit BCD, drives the fare counter.
REQ-011 SHALL have port t_min  output  8  waiting minutes, 2-digit BCD, drives the fare counter.
REQ-012 SHALL have port meter_reset  output  1  fare counter clear, drives its reset input.
REQ-013 SHALL have port run  output  1  1 = distance pricing; drives the fare counter's stop input.
REQ-014 SHALL have port finish  output  1  freezes the fare counter.
REQ-015 SHALL have port trip_state  output  3  current state encoding (IDLE=0, CLEAR=1, DRIVE=2, WAIT=3, DONE=4).

Function
REQ-016 SHALL implement the states IDLE, CLEAR, DRIVE, WAIT and DONE, with all outputs registered.
REQ-017 IDLE SHALL move to CLEAR on start, and SHALL ignore end_trip, pause, wheel_pulse and sec_tick.
REQ-018 CLEAR SHALL last exactly one cycle: zero dis, t_min, pulse counter and second counter; go to DRIVE if pause=0, else WAIT.
REQ-019 DRIVE SHALL go to WAIT when pause=1; WAIT SHALL go to DRIVE when pause=0; transition occurs next edge.
REQ-020 In DRIVE or WAIT, end_trip SHALL take priority over pause and move to DONE.
REQ-021 DONE SHALL hold dis and t_min, SHALL go to CLEAR on start, and SHALL ignore end_trip.
REQ-022 meter_reset SHALL be 1 in IDLE and CLEAR, 0 otherwise.
REQ-023 run SHALL be 1 only in DRIVE.
REQ-024 finish SHALL be 1 only in DONE.
REQ-025 wheel_pulse SHALL be counted only in DRIVE, including the cycle the DRIVE->WAIT move is taken.
REQ-026 When the pulse counter equals PULSES_PER_KM-1 and a pulse arrives, the counter SHALL wrap to 0 and dis SHALL increment by 1 in BCD (digit 9 carries).
REQ-027 dis SHALL saturate at BCD 999; once saturated, the pulse counter SHALL hold.
REQ-028 sec_tick SHALL be counted only in WAIT, and a partial minute SHALL be retained across WAIT->DRIVE->WAIT.
REQ-029 When the second counter equals TICKS_PER_MIN-1 and a tick arrives, the second counter SHALL wrap to 0 and t_min SHALL increment by 1 in BCD.
REQ-030 t_min SHALL saturate at BCD 99; once saturated, the second counter SHALL hold.
REQ-031 dis and t_min SHALL update one cycle after the qualifying pulse.
REQ-032 A pulse coincident with a state transition SHALL be judged by the current (pre-edge) state.

Reset
REQ-033 While reset=0, state SHALL be IDLE, dis=12'h000, t_min=8'h00, internal counters 0, meter_reset=1, run=0, finish=0, trip_state=0.
REQ-034 Asserting reset mid-trip SHALL force these values immediately, without waiting for clk.
REQ-035 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-036 Reset, then start with pause=0 SHALL give one cycle of CLEAR (meter_reset=1), then DRIVE (run=1, meter_reset=0).
REQ-037 In DRIVE, 25 wheel_pulses SHALL give dis=12'h002, and 5 more SHALL give dis=12'h003.
REQ-038 pause=1, then 150 sec_ticks SHALL give t_min=8'h02; pause=0, 30 ticks, pause=1, 30 ticks SHALL give t_min=8'h03.
REQ-039 end_trip and pause=1 in the same DRIVE cycle SHALL give DONE (finish=1, run=0), with dis and t_min held against further pulses.
REQ-040 With dis preloaded to 998 via pulses, 30 more pulses SHALL hold dis=12'h999; start from DONE SHALL then clear dis to 12'h000.
REQ-041 reset=0 asynchronously during WAIT SHALL immediately give trip_state=0, meter_reset=1, t_min=8'h00.
